dac_cfg_axi_master: RTL and testbench
=====================================

DAC_CFG_AXI_MASTER -- requirements
Module: dac_cfg_axi_master

Interface
REQ-001 Parameter NUM_REGS, default 8, number of table entries written per configuration run (1..64).
REQ-002 Parameter TIMEOUT_CYC, default 1024, maximum clocks spent waiting on any single AXI handshake.
REQ-003 clk_50m_bufg  input  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 dac_ready  input  1  level; rising edge starts a configuration run.
REQ-006 tx_reset_done_dac  input  1  JESD204 TX reset-done status.
REQ-007 dac_axi_awaddr/awvalid/awready  out/out/in  12/1/1  AXI-Lite write address channel.
REQ-008 dac_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI-Lite write data channel; wstrb is constant 4'hF.
REQ-009 dac_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite write response channel.
REQ-010 dac_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  out/out/in, in/in/in/out  12/1/1, 32/2/1/1  AXI-Lite read channels.
REQ-011 cfg_done  output  1  configuration completed and TX reset done.
REQ-012 cfg_err  output  1  sticky error flag.
REQ-013 cfg_idx  output  6  index of the table entry currently being processed.

Function
REQ-014 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT, WAIT_RST, DONE, ERR.
REQ-015 IDLE->WR_REQ on a registered dac_ready rising edge (0->1); awvalid and wvalid SHALL both assert on the next clock.
REQ-016 In WR_REQ, awvalid and wvalid each stay high with stable addr/data until their own ready is seen, then drop independently; move to WR_RESP once both handshakes have completed, in any order or in the same cycle.
REQ-017 In WR_RESP, bready=1; bvalid with bresp=2'b00 moves to RD_REQ (macro on) or NEXT (macro off); a nonzero bresp moves to ERR.
REQ-018 NEXT: if cfg_idx==NUM_REGS-1, go to WAIT_RST, otherwise increment cfg_idx and go to WR_REQ; there is no wrap-around past NUM_REGS-1.
REQ-019 WAIT_RST->DONE when tx_reset_done_dac=1; cfg_done=1 only in DONE.
REQ-020 A 16-bit timeout counter clears on every state entry; when it reaches TIMEOUT_CYC in WR_REQ, WR_RESP, RD_REQ, RD_RESP or WAIT_RST, go to ERR and drop all valid outputs.
REQ-021 ERR sets cfg_err and holds; DONE holds; both return to IDLE (clearing cfg_err, cfg_idx and cfg_done) only when dac_ready goes low.
REQ-022 If dac_ready falls mid-run, the current AXI transaction SHALL complete (no valid withdrawn before its ready) and the FSM then returns to IDLE.
REQ-023 The register table is a combinational lookup indexed by cfg_idx, giving {addr[11:0], data[31:0]}.

Reset
REQ-024 While sys_rst_n=0: state=IDLE; all valid, bready and rready outputs 0; addr/data outputs 0; cfg_done=0; cfg_err=0; cfg_idx=0; timeout counter 0; edge register 0.
REQ-025 Reset asserted mid-transaction SHALL abort immediately, without completing the handshake.

Configuration
REQ-026 Macro DAC_CFG_READBACK_EN: when defined, each accepted write is followed by an AXI read of the same address (RD_REQ holds arvalid until arready; RD_RESP holds rready=1); an rdata mismatch or nonzero rresp goes to ERR. When undefined, the RD_* states and read logic are absent, arvalid and rready are tied to 0, and araddr is tied to 0.

Structure
REQ-027 Package dac_cfg_pkg SHALL hold the state enum, the AXI response constants (OKAY=2'b00), the table entry typedef and the default register table.
REQ-028 Sub-module dac_cfg_rom SHALL implement the table lookup (REQ-023); the FSM, handshake and timeout logic stay in dac_cfg_axi_master.

Verification
REQ-029 Reset, raise dac_ready, zero-wait slave -> exactly 8 writes, addresses in table order, first awvalid 2 clocks after dac_ready rises; cfg_done=1 after tx_reset_done_dac=1.
REQ-030 Slave gives wready 3 clocks before awready -> wvalid drops first, awaddr stays stable, exactly one write is counted.
REQ-031 bresp=2'b10 on entry 3 -> cfg_err=1, cfg_idx=3, no further writes.
REQ-032 awready held low -> ERR exactly TIMEOUT_CYC clocks after WR_REQ entry.
REQ-033 Readback enabled, rdata differs on entry 5 -> cfg_err=1; with the macro undefined, arvalid stays 0 for the whole run.
REQ-034 sys_rst_n pulsed low during WR_RESP -> all outputs return to their reset values asynchronously; a new dac_ready edge restarts the run at cfg_idx=0.

Source files
------------

// File: rtl/dac_cfg_pkg.sv
// Shared types for the DAC configuration master: FSM states, AXI response codes, register table.
// No logic; the table is a constant consumed combinationally by dac_cfg_rom.
// DAC_CFG_READBACK_EN adds the RD_REQ/RD_RESP states to the state enum.
package dac_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
`ifdef DAC_CFG_READBACK_EN
    RD_REQ,
    RD_RESP,
`endif
    NEXT,
    WAIT_RST,
    DONE,
    ERR
  } dac_cfg_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } dac_cfg_entry_t;

  localparam int DAC_CFG_TABLE_LEN = 8;

  // Default bring-up sequence; element 0 sits in the least significant slot.
  localparam dac_cfg_entry_t [DAC_CFG_TABLE_LEN-1:0] DAC_CFG_TABLE = {
    {12'h034, 32'h0000_0001},  // 7: enable JESD link
    {12'h030, 32'hCAFE_0001},  // 6: lane crossbar
    {12'h024, 32'h0000_0003},  // 5: interpolation mode
    {12'h020, 32'h1234_5678},  // 4: NCO frequency word
    {12'h014, 32'h0000_00A5},  // 3: serdes PLL config
    {12'h010, 32'h0001_0080},  // 2: clock divider
    {12'h004, 32'h0000_0F03},  // 1: power-down mask
    {12'h000, 32'h0000_0001}   // 0: soft reset
  };

endpackage

// File: rtl/dac_cfg_rom.sv
// Register table lookup: index -> {addr, data}.
// Latency: purely combinational.
// Backpressure: none; the caller holds the index stable as long as it needs the entry.
module dac_cfg_rom
  import dac_cfg_pkg::*;
(
  input  logic [5:0]     idx,
  output dac_cfg_entry_t entry
);

  // Indices past the default table get a generated filler with a unique address.
  always_comb begin
    entry = DAC_CFG_TABLE[idx[2:0]];
    if (idx >= 6'(DAC_CFG_TABLE_LEN)) begin
      entry.addr = 12'h100 + {4'h0, idx, 2'b00};
      entry.data = {26'h0, idx};
    end
  end

endmodule

// File: rtl/dac_cfg_axi_master.sv
// AXI-Lite master that writes the DAC register table after dac_ready rises, then waits for TX reset done.
// Latency: first awvalid two clocks after dac_ready rises; one write (plus optional readback) per entry.
// Backpressure: valids are held until their ready; each handshake is bounded by TIMEOUT_CYC, then ERR.
// Optional feature: define DAC_CFG_READBACK_EN to read back and compare every accepted write.
module dac_cfg_axi_master
  import dac_cfg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_50m_bufg,
  input  logic        sys_rst_n,
  input  logic        dac_ready,
  input  logic        tx_reset_done_dac,
  output logic [11:0] dac_axi_awaddr,
  output logic        dac_axi_awvalid,
  input  logic        dac_axi_awready,
  output logic [31:0] dac_axi_wdata,
  output logic [3:0]  dac_axi_wstrb,
  output logic        dac_axi_wvalid,
  input  logic        dac_axi_wready,
  input  logic [1:0]  dac_axi_bresp,
  input  logic        dac_axi_bvalid,
  output logic        dac_axi_bready,
  output logic [11:0] dac_axi_araddr,
  output logic        dac_axi_arvalid,
  input  logic        dac_axi_arready,
  input  logic [31:0] dac_axi_rdata,
  input  logic [1:0]  dac_axi_rresp,
  input  logic        dac_axi_rvalid,
  output logic        dac_axi_rready,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [5:0]  cfg_idx
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [5:0]  IDX_LAST = 6'(NUM_REGS - 1);

  dac_cfg_state_t state;
  logic           dac_ready_q;
  logic           dac_ready_qq;
  logic           aw_done;
  logic           w_done;
  logic [15:0]    tmo_cnt;
  logic [5:0]     rom_idx;
  dac_cfg_entry_t rom_entry;
  logic           aw_hs;
  logic           w_hs;
  logic           tmo_hit;
  logic           ready_rise;

  assign dac_axi_wstrb = 4'hF;
  assign aw_hs         = dac_axi_awvalid & dac_axi_awready;
  assign w_hs          = dac_axi_wvalid & dac_axi_wready;
  assign tmo_hit       = (tmo_cnt == TMO_LAST);
  assign ready_rise    = dac_ready_q & ~dac_ready_qq;

  // Look ahead one entry in NEXT so the address/data registers load the entry about to be written.
  always_comb begin
    rom_idx = cfg_idx;
    if (state == NEXT) begin
      rom_idx = cfg_idx + 6'd1;
    end
  end

  dac_cfg_rom u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

`ifdef DAC_CFG_READBACK_EN
  logic [11:0] araddr_r;
  logic        arvalid_r;
  logic        rready_r;
  assign dac_axi_araddr  = araddr_r;
  assign dac_axi_arvalid = arvalid_r;
  assign dac_axi_rready  = rready_r;
`else
  logic unused_rd;
  assign unused_rd       = ^{dac_axi_arready, dac_axi_rdata, dac_axi_rresp, dac_axi_rvalid};
  assign dac_axi_araddr  = 12'h000;
  assign dac_axi_arvalid = 1'b0;
  assign dac_axi_rready  = 1'b0;
`endif

  // Main sequencer: edge detect, AXI handshakes, per-state timeout and registered outputs.
  always_ff @(posedge clk_50m_bufg or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      dac_ready_q     <= 1'b0;
      dac_ready_qq    <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      tmo_cnt         <= '0;
      dac_axi_awaddr  <= '0;
      dac_axi_awvalid <= 1'b0;
      dac_axi_wdata   <= '0;
      dac_axi_wvalid  <= 1'b0;
      dac_axi_bready  <= 1'b0;
`ifdef DAC_CFG_READBACK_EN
      araddr_r        <= '0;
      arvalid_r       <= 1'b0;
      rready_r        <= 1'b0;
`endif
      cfg_done        <= 1'b0;
      cfg_err         <= 1'b0;
      cfg_idx         <= '0;
    end else begin
      dac_ready_q  <= dac_ready;
      dac_ready_qq <= dac_ready_q;
      // Counter is zero on every state entry; timed states override with an increment.
      tmo_cnt      <= '0;
      case (state)
        IDLE: begin
          if (ready_rise) begin
            state           <= WR_REQ;
            dac_axi_awaddr  <= rom_entry.addr;
            dac_axi_wdata   <= rom_entry.data;
            dac_axi_awvalid <= 1'b1;
            dac_axi_wvalid  <= 1'b1;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
          end
        end

        WR_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (aw_hs) begin
            dac_axi_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            dac_axi_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state          <= WR_RESP;
            dac_axi_bready <= 1'b1;
            tmo_cnt        <= '0;
          end else if (tmo_hit) begin
            state           <= ERR;
            dac_axi_awvalid <= 1'b0;
            dac_axi_wvalid  <= 1'b0;
            cfg_err         <= 1'b1;
            tmo_cnt         <= '0;
          end
        end

        WR_RESP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (dac_axi_bvalid) begin
            dac_axi_bready <= 1'b0;
            tmo_cnt        <= '0;
            if (dac_axi_bresp != AXI_RESP_OKAY) begin
              state   <= ERR;
              cfg_err <= 1'b1;
            end else if (!dac_ready_q) begin
              // Run abandoned: the write has completed, skip any readback.
              state   <= IDLE;
              cfg_idx <= '0;
            end else begin
`ifdef DAC_CFG_READBACK_EN
              state     <= RD_REQ;
              araddr_r  <= dac_axi_awaddr;
              arvalid_r <= 1'b1;
`else
              state <= NEXT;
`endif
            end
          end else if (tmo_hit) begin
            state          <= ERR;
            dac_axi_bready <= 1'b0;
            cfg_err        <= 1'b1;
            tmo_cnt        <= '0;
          end
        end

`ifdef DAC_CFG_READBACK_EN
        RD_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (dac_axi_arready) begin
            state     <= RD_RESP;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            tmo_cnt   <= '0;
          end else if (tmo_hit) begin
            state     <= ERR;
            arvalid_r <= 1'b0;
            cfg_err   <= 1'b1;
            tmo_cnt   <= '0;
          end
        end

        RD_RESP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (dac_axi_rvalid) begin
            rready_r <= 1'b0;
            tmo_cnt  <= '0;
            // wdata still holds the value just written, so it doubles as the compare reference.
            if ((dac_axi_rresp != AXI_RESP_OKAY) || (dac_axi_rdata != dac_axi_wdata)) begin
              state   <= ERR;
              cfg_err <= 1'b1;
            end else if (!dac_ready_q) begin
              state   <= IDLE;
              cfg_idx <= '0;
            end else begin
              state <= NEXT;
            end
          end else if (tmo_hit) begin
            state    <= ERR;
            rready_r <= 1'b0;
            cfg_err  <= 1'b1;
            tmo_cnt  <= '0;
          end
        end
`endif

        NEXT: begin
          if (!dac_ready_q) begin
            state   <= IDLE;
            cfg_idx <= '0;
          end else if (cfg_idx == IDX_LAST) begin
            state <= WAIT_RST;
          end else begin
            state           <= WR_REQ;
            cfg_idx         <= cfg_idx + 6'd1;
            dac_axi_awaddr  <= rom_entry.addr;
            dac_axi_wdata   <= rom_entry.data;
            dac_axi_awvalid <= 1'b1;
            dac_axi_wvalid  <= 1'b1;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
          end
        end

        WAIT_RST: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (!dac_ready_q) begin
            state   <= IDLE;
            cfg_idx <= '0;
            tmo_cnt <= '0;
          end else if (tx_reset_done_dac) begin
            state    <= DONE;
            cfg_done <= 1'b1;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state   <= ERR;
            cfg_err <= 1'b1;
            tmo_cnt <= '0;
          end
        end

        DONE: begin
          if (!dac_ready_q) begin
            state    <= IDLE;
            cfg_done <= 1'b0;
            cfg_idx  <= '0;
          end
        end

        ERR: begin
          if (!dac_ready_q) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
            cfg_idx <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_cfg_axi_master.sv
// Directed bench for dac_cfg_axi_master with a configurable AXI-Lite slave.
// Table of run scenarios plus hand sequences for latency, timeout, async reset and mid-run abort.
// Slave readies are decided on the falling edge so every handshake is known before it happens.
module tb_dac_cfg_axi_master;

  localparam int TMO = 40;

  logic        clk_50m_bufg;
  logic        sys_rst_n;
  logic        dac_ready;
  logic        tx_reset_done_dac;
  logic [11:0] dac_axi_awaddr;
  logic        dac_axi_awvalid;
  logic        dac_axi_awready;
  logic [31:0] dac_axi_wdata;
  logic [3:0]  dac_axi_wstrb;
  logic        dac_axi_wvalid;
  logic        dac_axi_wready;
  logic [1:0]  dac_axi_bresp;
  logic        dac_axi_bvalid;
  logic        dac_axi_bready;
  logic [11:0] dac_axi_araddr;
  logic        dac_axi_arvalid;
  logic        dac_axi_arready;
  logic [31:0] dac_axi_rdata;
  logic [1:0]  dac_axi_rresp;
  logic        dac_axi_rvalid;
  logic        dac_axi_rready;
  logic        cfg_done;
  logic        cfg_err;
  logic [5:0]  cfg_idx;

  dac_cfg_axi_master #(.NUM_REGS(8), .TIMEOUT_CYC(TMO)) dut (
    .clk_50m_bufg(clk_50m_bufg), .sys_rst_n(sys_rst_n), .dac_ready(dac_ready),
    .tx_reset_done_dac(tx_reset_done_dac),
    .dac_axi_awaddr(dac_axi_awaddr), .dac_axi_awvalid(dac_axi_awvalid), .dac_axi_awready(dac_axi_awready),
    .dac_axi_wdata(dac_axi_wdata), .dac_axi_wstrb(dac_axi_wstrb), .dac_axi_wvalid(dac_axi_wvalid),
    .dac_axi_wready(dac_axi_wready),
    .dac_axi_bresp(dac_axi_bresp), .dac_axi_bvalid(dac_axi_bvalid), .dac_axi_bready(dac_axi_bready),
    .dac_axi_araddr(dac_axi_araddr), .dac_axi_arvalid(dac_axi_arvalid), .dac_axi_arready(dac_axi_arready),
    .dac_axi_rdata(dac_axi_rdata), .dac_axi_rresp(dac_axi_rresp), .dac_axi_rvalid(dac_axi_rvalid),
    .dac_axi_rready(dac_axi_rready),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_idx(cfg_idx)
  );

  initial clk_50m_bufg = 1'b0;
  always #5 clk_50m_bufg = ~clk_50m_bufg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_addr [8];
  logic [31:0] exp_data [8];

  // slave configuration and bookkeeping
  int  aw_lat, w_lat, aw_wait, w_wait;
  int  bad_b_idx, bad_r_idx, b_stall_idx;
  bit  aw_stall;
  int  wr_cnt, w_cnt, seq_err, proto_err, ar_seen;
  logic [11:0] aw_log [16];
  logic [31:0] wd_log [16];
  bit  pv_aw, pv_w, p_aw_hs, p_w_hs;
  logic [11:0] p_awaddr;
  logic [31:0] p_wdata;

  typedef struct {
    int aw_lat;
    int w_lat;
    int bad_b;
    int bad_r;
    bit txdone;
    int exp_wr;
    bit exp_done;
    bit exp_err;
    int exp_idx;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic slave_step();
    int ri;
    if (!sys_rst_n) begin
      dac_axi_awready = 0; dac_axi_wready = 0; dac_axi_bvalid = 0; dac_axi_bresp = 0;
      dac_axi_arready = 0; dac_axi_rvalid = 0; dac_axi_rresp = 0; dac_axi_rdata = 0;
      pv_aw = 0; pv_w = 0; p_aw_hs = 0; p_w_hs = 0; aw_wait = 0; w_wait = 0;
      return;
    end
    // valid must not be withdrawn nor its payload change before the handshake (timeout excepted)
    if (!cfg_err) begin
      if (pv_aw && !p_aw_hs && (!dac_axi_awvalid || dac_axi_awaddr != p_awaddr)) proto_err++;
      if (pv_w && !p_w_hs && (!dac_axi_wvalid || dac_axi_wdata != p_wdata)) proto_err++;
    end
    if (dac_axi_arvalid) ar_seen++;

    p_aw_hs = 0;
    if (dac_axi_awvalid && !aw_stall && aw_wait >= aw_lat) begin
      dac_axi_awready = 1; p_aw_hs = 1; aw_wait = 0;
      if (wr_cnt < 8) begin
        if (dac_axi_awaddr != exp_addr[wr_cnt]) seq_err++;
      end else seq_err++;
      if (wr_cnt < 16) aw_log[wr_cnt] = dac_axi_awaddr;
      wr_cnt++;
    end else begin
      dac_axi_awready = 0;
      aw_wait = dac_axi_awvalid ? aw_wait + 1 : 0;
    end

    p_w_hs = 0;
    if (dac_axi_wvalid && w_wait >= w_lat) begin
      dac_axi_wready = 1; p_w_hs = 1; w_wait = 0;
      if (w_cnt < 8) begin
        if (dac_axi_wdata != exp_data[w_cnt]) seq_err++;
      end else seq_err++;
      if (w_cnt < 16) wd_log[w_cnt] = dac_axi_wdata;
      w_cnt++;
    end else begin
      dac_axi_wready = 0;
      w_wait = dac_axi_wvalid ? w_wait + 1 : 0;
    end

    pv_aw = dac_axi_awvalid; p_awaddr = dac_axi_awaddr;
    pv_w  = dac_axi_wvalid;  p_wdata  = dac_axi_wdata;

    if (dac_axi_bready && (wr_cnt - 1) != b_stall_idx) begin
      dac_axi_bvalid = 1;
      dac_axi_bresp  = ((wr_cnt - 1) == bad_b_idx) ? 2'b10 : 2'b00;
    end else begin
      dac_axi_bvalid = 0;
      dac_axi_bresp  = 2'b00;
    end

    dac_axi_arready = dac_axi_arvalid;
    ri = (w_cnt > 0 && w_cnt <= 16) ? w_cnt - 1 : 0;
    if (dac_axi_rready) begin
      dac_axi_rvalid = 1;
      dac_axi_rdata  = wd_log[ri] ^ ((ri == bad_r_idx) ? 32'h0000_0100 : 32'h0);
    end else begin
      dac_axi_rvalid = 0;
      dac_axi_rdata  = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_50m_bufg);
      slave_step();
    end
  end

  task automatic do_reset();
    sys_rst_n = 0;
    dac_ready = 0;
    @(negedge clk_50m_bufg); #1;
    tx_reset_done_dac = 1; aw_stall = 0; aw_lat = 0; w_lat = 0;
    bad_b_idx = -1; bad_r_idx = -1; b_stall_idx = -1;
    wr_cnt = 0; w_cnt = 0; seq_err = 0;
    repeat (2) @(negedge clk_50m_bufg);
    sys_rst_n = 1;
    @(negedge clk_50m_bufg);
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_50m_bufg); #1;
      if (cfg_done || cfg_err) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_bready_at(input int n_wr, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_50m_bufg); #1;
      if (wr_cnt == n_wr && dac_axi_bready) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    exp_addr[0] = 12'h000; exp_data[0] = 32'h0000_0001;
    exp_addr[1] = 12'h004; exp_data[1] = 32'h0000_0F03;
    exp_addr[2] = 12'h010; exp_data[2] = 32'h0001_0080;
    exp_addr[3] = 12'h014; exp_data[3] = 32'h0000_00A5;
    exp_addr[4] = 12'h020; exp_data[4] = 32'h1234_5678;
    exp_addr[5] = 12'h024; exp_data[5] = 32'h0000_0003;
    exp_addr[6] = 12'h030; exp_data[6] = 32'hCAFE_0001;
    exp_addr[7] = 12'h034; exp_data[7] = 32'h0000_0001;

    //            aw  w  badb badr tx  wr done err idx
    vecs[0] = '{0, 0, -1, -1, 1, 8, 1, 0, 7};  // zero-wait slave
    vecs[1] = '{3, 0, -1, -1, 1, 8, 1, 0, 7};  // wready 3 clocks before awready
    vecs[2] = '{0, 2, -1, -1, 1, 8, 1, 0, 7};  // awready first
    vecs[3] = '{0, 0,  3, -1, 1, 4, 0, 1, 3};  // SLVERR on entry 3
`ifdef DAC_CFG_READBACK_EN
    vecs[4] = '{0, 0, -1,  5, 1, 6, 0, 1, 5};  // readback differs on entry 5
`else
    vecs[4] = '{0, 0, -1,  5, 1, 8, 1, 0, 7};  // no readback: corrupted rdata is never seen
`endif
    vecs[5] = '{0, 0,  0, -1, 1, 1, 0, 1, 0};  // SLVERR on first entry
    vecs[6] = '{1, 1,  7, -1, 1, 8, 0, 1, 7};  // SLVERR on last entry
    vecs[7] = '{0, 0, -1, -1, 0, 8, 0, 1, 7};  // TX reset never done

    proto_err = 0; ar_seen = 0;
    sys_rst_n = 1; dac_ready = 0; tx_reset_done_dac = 1;
    aw_stall = 0; aw_lat = 0; w_lat = 0; bad_b_idx = -1; bad_r_idx = -1; b_stall_idx = -1;
    wr_cnt = 0; w_cnt = 0; seq_err = 0;

    // reset values while reset is held
    #2 sys_rst_n = 0;
    #3;
    check("rst_awvalid", dac_axi_awvalid, 0);
    check("rst_wvalid", dac_axi_wvalid, 0);
    check("rst_bready", dac_axi_bready, 0);
    check("rst_arvalid", dac_axi_arvalid, 0);
    check("rst_rready", dac_axi_rready, 0);
    check("rst_awaddr", dac_axi_awaddr, 0);
    check("rst_wdata", dac_axi_wdata, 0);
    check("rst_araddr", dac_axi_araddr, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_idx", cfg_idx, 0);
    check("wstrb", dac_axi_wstrb, 4'hF);

    // first-write latency, then awready held low until the timeout fires
    do_reset();
    aw_stall = 1;
    dac_ready = 1;
    @(negedge clk_50m_bufg); #1;
    check("lat_awvalid_1clk", dac_axi_awvalid, 0);
    @(negedge clk_50m_bufg); #1;
    check("lat_awvalid_2clk", dac_axi_awvalid, 1);
    check("lat_wvalid_2clk", dac_axi_wvalid, 1);
    check("lat_awaddr", dac_axi_awaddr, exp_addr[0]);
    cnt = 0;
    while (!cfg_err && cnt < TMO + 20) begin
      @(negedge clk_50m_bufg); #1;
      cnt++;
    end
    check("tmo_cycles", cnt, TMO);
    check("tmo_err", cfg_err, 1);
    check("tmo_awvalid_dropped", dac_axi_awvalid, 0);
    check("tmo_idx", cfg_idx, 0);
    check("tmo_writes", wr_cnt, 0);

    // scenario table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      aw_lat = vecs[v].aw_lat; w_lat = vecs[v].w_lat;
      bad_b_idx = vecs[v].bad_b; bad_r_idx = vecs[v].bad_r;
      tx_reset_done_dac = vecs[v].txdone;
      dac_ready = 1;
      wait_end(3000, ok);
      check($sformatf("v%0d_finished", v), ok, 1);
      repeat (20) @(negedge clk_50m_bufg);
      #1;
      check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_wr);
      check($sformatf("v%0d_wdata_beats", v), w_cnt, vecs[v].exp_wr);
      check($sformatf("v%0d_order", v), seq_err, 0);
      check($sformatf("v%0d_done", v), cfg_done, vecs[v].exp_done);
      check($sformatf("v%0d_err", v), cfg_err, vecs[v].exp_err);
      check($sformatf("v%0d_idx", v), cfg_idx, vecs[v].exp_idx);
      dac_ready = 0;
      repeat (4) @(negedge clk_50m_bufg);
      #1;
      check($sformatf("v%0d_rel_done", v), cfg_done, 0);
      check($sformatf("v%0d_rel_err", v), cfg_err, 0);
      check($sformatf("v%0d_rel_idx", v), cfg_idx, 0);
    end

    // asynchronous reset while waiting for the second write response, then restart
    do_reset();
    b_stall_idx = 1;
    dac_ready = 1;
    wait_bready_at(2, 200, ok);
    check("arst_reached_wr_resp", ok, 1);
    check("arst_idx_before", cfg_idx, 1);
    #1 sys_rst_n = 0;
    #1;
    check("arst_bready", dac_axi_bready, 0);
    check("arst_awaddr", dac_axi_awaddr, 0);
    check("arst_wdata", dac_axi_wdata, 0);
    check("arst_idx", cfg_idx, 0);
    check("arst_done_err", {cfg_done, cfg_err}, 0);
    do_reset();
    dac_ready = 1;
    wait_end(3000, ok);
    check("restart_finished", ok, 1);
    check("restart_first_addr", aw_log[0], exp_addr[0]);
    check("restart_writes", wr_cnt, 8);
    check("restart_order", seq_err, 0);
    check("restart_done", cfg_done, 1);

    // dac_ready falls while a write response is outstanding
    do_reset();
    b_stall_idx = 2;
    dac_ready = 1;
    wait_bready_at(3, 200, ok);
    check("abort_reached_wr_resp", ok, 1);
    dac_ready = 0;
    repeat (4) @(negedge clk_50m_bufg);
    #1;
    check("abort_bready_held", dac_axi_bready, 1);
    check("abort_idx_held", cfg_idx, 2);
    b_stall_idx = -1;
    repeat (10) @(negedge clk_50m_bufg);
    #1;
    check("abort_writes", wr_cnt, 3);
    check("abort_idx_cleared", cfg_idx, 0);
    check("abort_awvalid", dac_axi_awvalid, 0);
    check("abort_bready_done", dac_axi_bready, 0);
    check("abort_done_err", {cfg_done, cfg_err}, 0);

    check("protocol_holds", proto_err, 0);
`ifdef DAC_CFG_READBACK_EN
    check("readback_used", (ar_seen > 0), 1);
`else
    check("arvalid_never", ar_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
